// File: rtl/fosfor_present_pkg.sv
// Shared PRESENT definitions: sizes, FSM encoding, S-box tables and layer functions.
// Inverse tables and layers exist only when FOSFOR_PRESENT_DECRYPT_EN is defined.
package fosfor_present_pkg;

  localparam int unsigned STATE_W = 64;
  localparam int unsigned ROUNDS  = 31;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FIN,
    KEXP,
    DRUN
  } fsm_t;

  // Nibble n of the table holds S(n)
  localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

  function automatic logic [3:0] sbox4(input logic [3:0] n);
    return SBOX_TABLE[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [STATE_W-1:0] sbox_layer(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < STATE_W / 4; i++) begin
      r[4*i +: 4] = sbox4(s[4*i +: 4]);
    end
    return r;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 stays in place
  function automatic logic [STATE_W-1:0] p_layer(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    r[STATE_W-1] = s[STATE_W-1];
    for (int unsigned i = 0; i < STATE_W - 1; i++) begin
      r[6'((16 * i) % 63)] = s[i];
    end
    return r;
  endfunction

`ifdef FOSFOR_PRESENT_DECRYPT_EN
  localparam logic [63:0] INV_SBOX_TABLE = 64'hA970364BD21C8FE5;

  function automatic logic [3:0] inv_sbox4(input logic [3:0] n);
    return INV_SBOX_TABLE[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [STATE_W-1:0] inv_sbox_layer(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < STATE_W / 4; i++) begin
      r[4*i +: 4] = inv_sbox4(s[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] inv_p_layer(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    r[STATE_W-1] = s[STATE_W-1];
    for (int unsigned i = 0; i < STATE_W - 1; i++) begin
      r[i] = s[6'((16 * i) % 63)];
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/fosfor_present_key_update.sv
// Combinational PRESENT key-schedule step for 80- or 128-bit keys.
// The inverse step is present only when FOSFOR_PRESENT_DECRYPT_EN is defined.
module fosfor_present_key_update
  import fosfor_present_pkg::*;
#(
  parameter int unsigned KEY_W = 80
) (
  input  logic [KEY_W-1:0] work_key,
  input  logic [4:0]       cnt,
  output logic [KEY_W-1:0] fwd_key
`ifdef FOSFOR_PRESENT_DECRYPT_EN
  ,
  output logic [KEY_W-1:0] inv_key
`endif
);

  logic [KEY_W-1:0] rot;

  assign rot = {work_key[KEY_W-62:0], work_key[KEY_W-1:KEY_W-61]};

`ifdef FOSFOR_PRESENT_DECRYPT_EN
  logic [KEY_W-1:0] unrot;

  // Undo counter XOR and S-box first, then rotate right by 61
  assign inv_key = {unrot[60:0], unrot[KEY_W-1:61]};
`endif

  if (KEY_W == 128) begin : g_k128
    always_comb begin
      fwd_key          = rot;
      fwd_key[127:124] = sbox4(rot[127:124]);
      fwd_key[123:120] = sbox4(rot[123:120]);
      fwd_key[66:62]   = rot[66:62] ^ cnt;
    end
`ifdef FOSFOR_PRESENT_DECRYPT_EN
    always_comb begin
      unrot          = work_key;
      unrot[66:62]   = work_key[66:62] ^ cnt;
      unrot[127:124] = inv_sbox4(work_key[127:124]);
      unrot[123:120] = inv_sbox4(work_key[123:120]);
    end
`endif
  end else begin : g_k80
    always_comb begin
      fwd_key        = rot;
      fwd_key[79:76] = sbox4(rot[79:76]);
      fwd_key[19:15] = rot[19:15] ^ cnt;
    end
`ifdef FOSFOR_PRESENT_DECRYPT_EN
    always_comb begin
      unrot        = work_key;
      unrot[19:15] = work_key[19:15] ^ cnt;
      unrot[79:76] = inv_sbox4(work_key[79:76]);
    end
`endif
  end

endmodule

// File: rtl/fosfor_present_core.sv
// Iterative PRESENT core: 64-bit block, 80/128-bit key, one round per clock, IO_W-bit bus.
// Decryption (Mode_i=1) is built only when FOSFOR_PRESENT_DECRYPT_EN is defined.
module fosfor_present_core
  import fosfor_present_pkg::*;
#(
  parameter int unsigned KEY_W = 80,
  parameter int unsigned IO_W  = 8
) (
  input  logic            Clk_k,
  input  logic            Reset_rn,
  input  logic            KeyWe_i,
  input  logic            BlkWe_i,
  input  logic            Rd_i,
  input  logic [IO_W-1:0] Data_ib,
  input  logic            Start_i,
  input  logic            Mode_i,
  output logic [IO_W-1:0] Data_ob,
  output logic            Busy_o,
  output logic            Done_o
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("fosfor_present_core: KEY_W must be 80 or 128");
  end
  if (IO_W != 1 && IO_W != 2 && IO_W != 4 && IO_W != 8 && IO_W != 16) begin : g_bad_io_w
    $error("fosfor_present_core: IO_W must be 1, 2, 4, 8 or 16");
  end

  fsm_t               fsm;
  logic [KEY_W-1:0]   key_reg;
  logic [KEY_W-1:0]   work_key;
  logic [KEY_W-1:0]   fwd_key;
  logic [STATE_W-1:0] blk;
  logic [4:0]         cnt;
  logic [STATE_W-1:0] round_key;

  assign round_key = work_key[KEY_W-1 -: STATE_W];
  assign Data_ob   = blk[STATE_W-1 -: IO_W];

`ifdef FOSFOR_PRESENT_DECRYPT_EN
  logic [KEY_W-1:0] inv_key;

  fosfor_present_key_update #(
    .KEY_W(KEY_W)
  ) u_key_update (
    .work_key(work_key),
    .cnt     (cnt),
    .fwd_key (fwd_key),
    .inv_key (inv_key)
  );
`else
  logic unused_mode;
  assign unused_mode = Mode_i;

  fosfor_present_key_update #(
    .KEY_W(KEY_W)
  ) u_key_update (
    .work_key(work_key),
    .cnt     (cnt),
    .fwd_key (fwd_key)
  );
`endif

  always_ff @(posedge Clk_k or negedge Reset_rn) begin
    if (!Reset_rn) begin
      fsm      <= IDLE;
      key_reg  <= '0;
      work_key <= '0;
      blk      <= '0;
      cnt      <= '0;
      Busy_o   <= 1'b0;
      Done_o   <= 1'b0;
    end else begin
      Done_o <= 1'b0;
      case (fsm)
        IDLE: begin
          // Start wins over same-cycle writes so the operation sees pre-edge contents
          if (Start_i) begin
            work_key <= key_reg;
            cnt      <= 5'd1;
            Busy_o   <= 1'b1;
            fsm      <= RUN;
`ifdef FOSFOR_PRESENT_DECRYPT_EN
            if (Mode_i) fsm <= KEXP;
`endif
          end else begin
            if (KeyWe_i) key_reg <= {key_reg[KEY_W-IO_W-1:0], Data_ib};
            if (BlkWe_i)   blk <= {blk[STATE_W-IO_W-1:0], Data_ib};
            else if (Rd_i) blk <= blk << IO_W;
          end
        end

        RUN: begin
          blk      <= p_layer(sbox_layer(blk ^ round_key));
          work_key <= fwd_key;
          cnt      <= cnt + 5'd1;
          if (cnt == 5'(ROUNDS)) fsm <= FIN;
        end

        FIN: begin
          blk    <= blk ^ round_key;
          Done_o <= 1'b1;
          Busy_o <= 1'b0;
          fsm    <= IDLE;
        end

`ifdef FOSFOR_PRESENT_DECRYPT_EN
        // Walk the schedule forward to K_32, whitening with it on the last step
        KEXP: begin
          work_key <= fwd_key;
          if (cnt == 5'(ROUNDS)) begin
            blk <= blk ^ fwd_key[KEY_W-1 -: STATE_W];
            fsm <= DRUN;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        DRUN: begin
          blk      <= inv_sbox_layer(inv_p_layer(blk)) ^ inv_key[KEY_W-1 -: STATE_W];
          work_key <= inv_key;
          cnt      <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            Done_o <= 1'b1;
            Busy_o <= 1'b0;
            fsm    <= IDLE;
          end
        end
`endif

        default: begin
          Busy_o <= 1'b0;
          fsm    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fosfor_present_core.sv
// Directed bench for fosfor_present_core: four builds (80/8, 128/8, 80/1, 80/16) share strobes.
// Decrypt vectors run when FOSFOR_PRESENT_DECRYPT_EN is defined.
module tb_fosfor_present_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_we, blk_we, rd, start, mode;
  logic [7:0]  d_a, d_b;
  logic [0:0]  d_1;
  logic [15:0] d_16;
  logic [7:0]  q_a, q_b;
  logic [0:0]  q_1;
  logic [15:0] q_16;
  logic        busy_a, busy_b, busy_1, busy_16;
  logic        done_a, done_b, done_1, done_16;
  logic [63:0] r_a, r_b, r_1, r_16;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  fosfor_present_core #(.KEY_W(80), .IO_W(8)) u_dut (
    .Clk_k(clk), .Reset_rn(rst_n), .KeyWe_i(key_we), .BlkWe_i(blk_we), .Rd_i(rd),
    .Data_ib(d_a), .Start_i(start), .Mode_i(mode), .Data_ob(q_a), .Busy_o(busy_a), .Done_o(done_a)
  );
  fosfor_present_core #(.KEY_W(128), .IO_W(8)) u_k128 (
    .Clk_k(clk), .Reset_rn(rst_n), .KeyWe_i(key_we), .BlkWe_i(blk_we), .Rd_i(rd),
    .Data_ib(d_b), .Start_i(start), .Mode_i(mode), .Data_ob(q_b), .Busy_o(busy_b), .Done_o(done_b)
  );
  fosfor_present_core #(.KEY_W(80), .IO_W(1)) u_io1 (
    .Clk_k(clk), .Reset_rn(rst_n), .KeyWe_i(key_we), .BlkWe_i(blk_we), .Rd_i(rd),
    .Data_ib(d_1), .Start_i(start), .Mode_i(mode), .Data_ob(q_1), .Busy_o(busy_1), .Done_o(done_1)
  );
  fosfor_present_core #(.KEY_W(80), .IO_W(16)) u_io16 (
    .Clk_k(clk), .Reset_rn(rst_n), .KeyWe_i(key_we), .BlkWe_i(blk_we), .Rd_i(rd),
    .Data_ib(d_16), .Start_i(start), .Mode_i(mode), .Data_ob(q_16), .Busy_o(busy_16), .Done_o(done_16)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_data();
    d_a = '0; d_b = '0; d_1 = '0; d_16 = '0;
  endtask

  // 128 strobes; the 80-bit builds keep the low 80 bits of k
  task automatic load_key(input logic [127:0] k);
    key_we = 1'b1;
    for (int t = 0; t < 128; t++) begin
      d_a  = k[127 - (t % 16) * 8 -: 8];
      d_b  = k[127 - (t % 16) * 8 -: 8];
      d_1  = k[127 - t];
      d_16 = k[127 - (t % 8) * 16 -: 16];
      tick();
    end
    key_we = 1'b0;
    clear_data();
  endtask

  // 64 strobes; every build ends with its last 64 shifted bits equal to the block
  task automatic load_blk(input logic [63:0] b80, input logic [63:0] b128, input bit with_rd);
    blk_we = 1'b1;
    rd     = with_rd;
    for (int t = 0; t < 64; t++) begin
      d_a  = b80[63 - (t % 8) * 8 -: 8];
      d_b  = b128[63 - (t % 8) * 8 -: 8];
      d_1  = b80[63 - t];
      d_16 = b80[63 - (t % 4) * 16 -: 16];
      tick();
    end
    blk_we = 1'b0;
    rd     = 1'b0;
    clear_data();
  endtask

  task automatic read_all();
    r_a = '0; r_b = '0; r_1 = '0; r_16 = '0;
    rd = 1'b1;
    for (int t = 0; t < 64; t++) begin
      if (t < 8) begin
        r_a = {r_a[55:0], q_a};
        r_b = {r_b[55:0], q_b};
      end
      if (t < 4) r_16 = {r_16[47:0], q_16};
      r_1 = {r_1[62:0], q_1};
      tick();
    end
    rd = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic m, input int exp_lat,
                        input bit wr_at_start, input bit noise);
    int lat;
    mode  = m;
    start = 1'b1;
    if (wr_at_start) begin
      key_we = 1'b1; blk_we = 1'b1;
      d_a = '1; d_b = '1; d_1 = '1; d_16 = '1;
    end
    tick();
    start = 1'b0; mode = 1'b0; key_we = 1'b0; blk_we = 1'b0;
    clear_data();
    check({tag, "_busy"}, {busy_a, busy_b, busy_1, busy_16}, 4'hF);
    lat = 0;
    while (!done_a && lat < 200) begin
      if (noise && lat >= 4 && lat < 8) begin
        start = 1'b1; key_we = 1'b1; rd = 1'b1;
        d_a = '1; d_b = '1; d_1 = '1; d_16 = '1;
      end else begin
        start = 1'b0; key_we = 1'b0; rd = 1'b0;
        clear_data();
      end
      tick();
      lat++;
    end
    start = 1'b0; key_we = 1'b0; rd = 1'b0;
    clear_data();
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_done_all"}, {done_a, done_b, done_1, done_16}, 4'hF);
    check({tag, "_busy_end"}, {busy_a, busy_b, busy_1, busy_16}, 4'h0);
    tick();
    check({tag, "_done_pulse"}, {done_a, done_b, done_1, done_16}, 4'h0);
  endtask

  task automatic abort_run();
    bit seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #2;
    check("abort_busy", {busy_a, busy_b, busy_1, busy_16}, 4'h0);
    check("abort_done", {done_a, done_b, done_1, done_16}, 4'h0);
    check("abort_data", {q_a, q_b, q_1, q_16}, 33'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done_a | done_b | done_1 | done_16) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    key_we = 1'b0; blk_we = 1'b0; rd = 1'b0; start = 1'b0; mode = 1'b0;
    clear_data();
    tick();
    tick();
    check("reset_busy", {busy_a, busy_b, busy_1, busy_16}, 4'h0);
    check("reset_done", {done_a, done_b, done_1, done_16}, 4'h0);
    check("reset_data", {q_a, q_b, q_1, q_16}, 33'h0);
    rst_n = 1'b1;
    tick();

    // key 0, pt 0; Rd held during the block load must not disturb it
    load_key('0);
    load_blk('0, '0, 1'b1);
    run_op("enc_zero", 1'b0, 32, 1'b0, 1'b0);
    read_all();
    check("enc_zero_80", r_a, 64'h5579C1387B228445);
    check("enc_zero_128", r_b, 64'h96DB702A2E6900AF);
    check("enc_zero_io1", r_1, 64'h5579C1387B228445);
    check("enc_zero_io16", r_16, 64'h5579C1387B228445);
    check("read_zero_fill", {q_a, q_b, q_1, q_16}, 33'h0);

    // all-ones key and block, then a repeat run without key reload
    load_key('1);
    load_blk('1, '1, 1'b0);
    run_op("enc_ones", 1'b0, 32, 1'b0, 1'b0);
    read_all();
    check("enc_ones_80", r_a, 64'h3333DCD3213210D2);
    check("enc_ones_io1", r_1, 64'h3333DCD3213210D2);
    check("enc_ones_io16", r_16, 64'h3333DCD3213210D2);
    load_blk('1, '1, 1'b0);
    run_op("enc_rerun", 1'b0, 32, 1'b0, 1'b0);
    read_all();
    check("enc_rerun_80", r_a, 64'h3333DCD3213210D2);

    // key 0, pt all ones across bus widths
    load_key('0);
    load_blk('1, '1, 1'b0);
    run_op("enc_kz", 1'b0, 32, 1'b0, 1'b0);
    read_all();
    check("enc_kz_80", r_a, 64'hA112FFC72F68417B);
    check("enc_kz_io1", r_1, 64'hA112FFC72F68417B);
    check("enc_kz_io16", r_16, 64'hA112FFC72F68417B);

    // writes in the Start cycle are dropped
    load_blk('0, '0, 1'b0);
    run_op("start_wr", 1'b0, 32, 1'b1, 1'b0);
    read_all();
    check("start_wr_80", r_a, 64'h5579C1387B228445);
    check("start_wr_128", r_b, 64'h96DB702A2E6900AF);

    // strobes while busy are ignored, including on the key register
    load_blk('0, '0, 1'b0);
    run_op("noise", 1'b0, 32, 1'b0, 1'b1);
    read_all();
    check("noise_80", r_a, 64'h5579C1387B228445);
    load_blk('0, '0, 1'b0);
    run_op("noise_key", 1'b0, 32, 1'b0, 1'b0);
    read_all();
    check("noise_key_80", r_a, 64'h5579C1387B228445);
    check("noise_key_128", r_b, 64'h96DB702A2E6900AF);

    // reset mid-operation clears the key register too
    load_key('1);
    load_blk('1, '1, 1'b0);
    abort_run();
    read_all();
    check("abort_state", {r_a, r_b}, 128'h0);
    load_blk('0, '0, 1'b0);
    run_op("post_abort", 1'b0, 32, 1'b0, 1'b0);
    read_all();
    check("post_abort_80", r_a, 64'h5579C1387B228445);
    check("post_abort_128", r_b, 64'h96DB702A2E6900AF);
    check("post_abort_io16", r_16, 64'h5579C1387B228445);

`ifdef FOSFOR_PRESENT_DECRYPT_EN
    load_blk(64'h5579C1387B228445, 64'h96DB702A2E6900AF, 1'b0);
    run_op("dec", 1'b1, 62, 1'b0, 1'b0);
    read_all();
    check("dec_80", r_a, 64'h0);
    check("dec_128", r_b, 64'h0);
    check("dec_io1", r_1, 64'h0);
    check("dec_io16", r_16, 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fosfor_present_core.md
Name: fosfor_present_core

Overview:
Parametrised iterative PRESENT block-cipher core: 64-bit block, 80- or 128-bit key, one round per clock. Key and block are loaded IO_W bits at a time and the result is read back IO_W bits at a time. This suits the 8-bit TinyTapeout pin budget of fosfor_present_top, which instantiates it with IO_W=8. It generalises the fixed 80-bit encrypt-only engine with selectable key width, bus width and an optional decrypt mode.

Parameters:
KEY_W, 80, key length; legal values are 80 or 128; anything else is an elaboration error.
IO_W, 8, load/unload bus width; legal values are 1, 2, 4, 8, 16; must divide 64 and KEY_W.

Ports:
Clk_k  in  1  clock, rising edge.
Reset_rn  in  1  asynchronous active-low reset.
KeyWe_i  in  1  shift Data_ib into the key register.
BlkWe_i  in  1  shift Data_ib into the state register.
Rd_i  in  1  shift the state register out by IO_W.
Data_ib  in  IO_W  load data, MSB-first.
Start_i  in  1  start an operation; sampled only in IDLE.
Mode_i  in  1  0 = encrypt, 1 = decrypt; ignored unless the macro is defined.
Data_ob  out  IO_W  combinational State[63 -: IO_W].
Busy_o  out  1  high while an operation is in progress.
Done_o  out  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset (asynchronous, Reset_rn=0): KeyReg, WorkKey, State, Cnt all 0; FSM=IDLE; Busy_o=0, Done_o=0, Data_ob=0.
- IDLE writes: KeyWe_i does KeyReg <= {KeyReg[KEY_W-IO_W-1:0], Data_ib}. BlkWe_i does State <= {State[63-IO_W:0], Data_ib}.
- IDLE read: Rd_i without BlkWe_i does State <= State << IO_W, zero-filled. Rd_i together with BlkWe_i behaves as BlkWe_i.
- Start_i in IDLE: WorkKey <= KeyReg; Cnt <= 1; Busy_o=1 from the next cycle. Write, read and Start strobes are ignored while Busy_o=1.
- Start with a write in the same cycle: the write is dropped and the operation uses the pre-edge contents.
- KeyReg is never modified by an operation, so repeat operations need no key reload.
- Round key: K_i = WorkKey[KEY_W-1 -: 64].
- Forward key update, KEY_W=80: rotate left 61; S-box on bits [79:76]; bits [19:15] ^= Cnt[4:0].
- Forward key update, KEY_W=128: rotate left 61; S-box on [127:124] and [123:120]; bits [66:62] ^= Cnt[4:0].
- Encrypt FSM: IDLE -> RUN -> FIN -> IDLE.
  - RUN, for Cnt=1..31, one cycle each: State <= P(S(State ^ K_Cnt)); WorkKey <= fwd_update(WorkKey, Cnt); Cnt++.
  - FIN: State <= State ^ K_32; Done_o=1 for one cycle; Busy_o drops together with Done_o.
  - Done_o is high in the 33rd cycle after the Start edge (32 clock edges of processing). The result is readable immediately.
- Cnt is 5 bits and wraps exactly at 31 -> FIN; there is no other wrap.
- Reset mid-operation aborts immediately; there is no partial result and Done_o is never emitted.

Optional Feature:
FOSFOR_PRESENT_DECRYPT_EN
- Defined, with Mode_i=1 at Start, the FSM is IDLE -> KEXP -> DRUN -> IDLE:
  - KEXP: 31 forward key updates, Cnt 1..31. The last KEXP cycle also does State ^= K_32.
  - DRUN: Cnt 31..1, State <= S^-1(P^-1(State)) ^ K_{Cnt}; WorkKey steps back by the inverse update (undo counter XOR with Cnt, inverse S-box on the top nibble(s), rotate right 61).
  - Done_o is high in the 63rd cycle after the Start edge.
- Not defined: Mode_i is ignored, no inverse tables are synthesised, and the encrypt-only timing above applies.

Decomposition:
- Package fosfor_present_pkg holds:
  - STATE_W=64, ROUNDS=31.
  - FSM state enum {IDLE, RUN, FIN, KEXP, DRUN}.
  - S-box and inverse S-box constant tables.
  - functions sbox_layer/inv_sbox_layer and p_layer/inv_p_layer (P: bit i -> 16*i mod 63, bit 63 fixed).
- One sub-module, fosfor_present_key_update: combinational forward and inverse update, parametrised by KEY_W.

Test Plan:
- Reset with KEY_W=80: key 0, pt 0000000000000000 -> Done_o 32 cycles after Start; read 0x5579C1387B228445 over 8 Rd_i strobes.
- Same configuration: key FFFF..FF (80 bits), pt FFFFFFFFFFFFFFFF -> 0x3333DCD3213210D2; second Start without reloading the key, block reloaded -> same result.
- KEY_W=128: key 0, pt 0 -> 0x96DB702A2E6900AF.
- Assert Start_i, KeyWe_i and Rd_i during RUN; assert Reset_rn=0 at round 10 -> strobes have no effect; after reset all outputs and registers are 0 and Done_o never pulses.
- IO_W=1 and IO_W=16 builds: key 0, pt FFFFFFFFFFFFFFFF -> 0xA112FFC72F68417B.
- With FOSFOR_PRESENT_DECRYPT_EN: key 0, ct 0x5579C1387B228445, Mode_i=1 -> 0 after 63 cycles; with KEY_W=128, decrypting 0x96DB702A2E6900AF -> 0.
